// File: rtl/tt_tern_pkg.sv
// Shared definitions for the weight readback block: size defaults, plane encoding, FSM states.
// No logic, so no latency.
// No flow control; the types here are used by the streaming logic that has it.
package tt_tern_pkg;

    localparam int MAX_IN_LEN_DEF  = 16;
    localparam int MAX_OUT_LEN_DEF = 8;
    localparam int BYTES_PER_PLANE = MAX_IN_LEN_DEF / 8;

    typedef enum logic {
        PLANE_MSB = 1'b0,
        PLANE_LSB = 1'b1
    } plane_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter width that stays at least one bit for degenerate sizes.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tt_um_unload_mux.sv
// Selects one byte (8 consecutive inputs) of a row/plane from the packed weight array.
// Purely combinational, zero latency.
// No flow control; the caller holds row/plane/byte steady while a beat is stalled.
module tt_um_unload_mux
    import tt_tern_pkg::*;
#(
    parameter int MAX_IN_LEN  = MAX_IN_LEN_DEF,
    parameter int MAX_OUT_LEN = MAX_OUT_LEN_DEF
) (
    input  logic [2*MAX_IN_LEN*MAX_OUT_LEN-1:0] weights,
    input  logic [cnt_w(MAX_OUT_LEN)-1:0]       row,
    input  plane_t                              plane,
    input  logic [cnt_w(MAX_IN_LEN/8)-1:0]      byte_idx,
    output logic [7:0]                          byte_dat
);

    localparam int WW = 2 * MAX_IN_LEN * MAX_OUT_LEN;
    localparam int IW = cnt_w(WW);

    // Input i of row r, plane p lives at i*2*MAX_OUT_LEN + r*2 + p.
    always_comb begin
        byte_dat = '0;
        for (int k = 0; k < 8; k++) begin
            byte_dat[k] = weights[IW'((int'(byte_idx) * 8 + k) * 2 * MAX_OUT_LEN
                                      + int'(row) * 2 + int'(plane))];
        end
    end

endmodule

// File: rtl/tt_um_unload.sv
// Streams the 2-plane weight array out as bytes, row-major, MSB plane first. UNLOAD_SNAPSHOT_EN freezes weights at start.
// First beat valid one cycle after the start edge; one beat per accepted cycle; done pulses one cycle after the last beat.
// Beat held (data and counters) until ui_ready; ena low freezes everything.
module tt_um_unload
    import tt_tern_pkg::*;
#(
    parameter int MAX_IN_LEN  = MAX_IN_LEN_DEF,
    parameter int MAX_OUT_LEN = MAX_OUT_LEN_DEF
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                ena,
    input  logic                                ui_start,
    input  logic                                ui_ready,
    input  logic [6:0]                          ui_param,
    input  logic [2*MAX_IN_LEN*MAX_OUT_LEN-1:0] ui_weights,
    output logic [7:0]                          uo_data,
    output logic                                uo_valid,
    output logic                                uo_busy,
    output logic                                uo_done
);

    localparam int BPP = MAX_IN_LEN / 8;
    localparam int RW  = cnt_w(MAX_OUT_LEN);
    localparam int BW  = cnt_w(BPP);
    localparam int WW  = 2 * MAX_IN_LEN * MAX_OUT_LEN;

    state_t          state;
    state_t          state_nxt;
    logic [RW-1:0]   row_cnt;
    logic [RW-1:0]   last_row;
    logic [RW-1:0]   sat_row;
    plane_t          plane_cnt;
    logic [BW-1:0]   byte_cnt;
    logic            start_evt;
    logic            accept;
    logic            byte_end;
    logic            plane_end;
    logic            final_beat;
    logic [WW-1:0]   src_w;
    logic [7:0]      mux_dat;
    logic            unused_param;

    assign unused_param = &{1'b0, ui_param[6:3]};

    assign start_evt  = ena && (state == ST_IDLE) && ui_start;
    assign accept     = ena && (state == ST_SEND) && ui_ready;
    assign byte_end   = (byte_cnt == BW'(BPP - 1));
    assign plane_end  = byte_end && (plane_cnt == PLANE_LSB);
    assign final_beat = plane_end && (row_cnt == last_row);

    // Requested rows beyond the array clamp to the last physical row.
    always_comb begin
        if (int'(ui_param[2:0]) >= MAX_OUT_LEN) begin
            sat_row = RW'(MAX_OUT_LEN - 1);
        end else begin
            sat_row = RW'(ui_param[2:0]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else if (ena) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (ui_start) state_nxt = ST_SEND;
            ST_SEND: if (ui_ready && final_beat) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The final beat leaves the counters parked; the next start clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt   <= '0;
            last_row  <= '0;
            plane_cnt <= PLANE_MSB;
            byte_cnt  <= '0;
        end else if (start_evt) begin
            row_cnt   <= '0;
            last_row  <= sat_row;
            plane_cnt <= PLANE_MSB;
            byte_cnt  <= '0;
        end else if (accept && !final_beat) begin
            if (!byte_end) begin
                byte_cnt <= byte_cnt + BW'(1);
            end else begin
                byte_cnt <= '0;
                if (plane_cnt == PLANE_MSB) begin
                    plane_cnt <= PLANE_LSB;
                end else begin
                    plane_cnt <= PLANE_MSB;
                    row_cnt   <= row_cnt + RW'(1);
                end
            end
        end
    end

`ifdef UNLOAD_SNAPSHOT_EN
    logic [WW-1:0] snap_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_w <= '0;
        end else if (start_evt) begin
            snap_w <= ui_weights;
        end
    end

    assign src_w = snap_w;
`else
    assign src_w = ui_weights;
`endif

    tt_um_unload_mux #(
        .MAX_IN_LEN  (MAX_IN_LEN),
        .MAX_OUT_LEN (MAX_OUT_LEN)
    ) u_mux (
        .weights  (src_w),
        .row      (row_cnt),
        .plane    (plane_cnt),
        .byte_idx (byte_cnt),
        .byte_dat (mux_dat)
    );

    assign uo_valid = (state == ST_SEND);
    assign uo_busy  = (state == ST_SEND) || (state == ST_DONE);
    assign uo_done  = (state == ST_DONE);
    assign uo_data  = uo_valid ? mux_dat : 8'h00;

endmodule

// File: tb/tb_tt_um_unload.sv
// Randomized bench for tt_um_unload against a row/plane/byte stream model; a second, smaller instance covers row clamping.
// Honours UNLOAD_SNAPSHOT_EN when choosing expected beats after a mid-transfer weight change.
module tb_tt_um_unload;
    import tt_tern_pkg::*;

    localparam int OUT_L = MAX_OUT_LEN_DEF;
    localparam int IN_L  = MAX_IN_LEN_DEF;
    localparam int WW    = 2 * IN_L * OUT_L;
    localparam int IW_TB = $clog2(WW);
    localparam int S_IN  = 8;
    localparam int S_OUT = 4;
    localparam int S_WW  = 2 * S_IN * S_OUT;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ena;
    logic          ui_start;
    logic          ui_ready;
    logic [6:0]    ui_param;
    logic [WW-1:0] ui_weights;
    logic [7:0]    uo_data;
    logic          uo_valid, uo_busy, uo_done;
    logic [7:0]    s_data;
    logic          s_valid, s_busy, s_done;

    logic [7:0]    exp_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;

    always #5 clk = ~clk;

    tt_um_unload dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_start(ui_start), .ui_ready(ui_ready),
        .ui_param(ui_param), .ui_weights(ui_weights),
        .uo_data(uo_data), .uo_valid(uo_valid), .uo_busy(uo_busy), .uo_done(uo_done)
    );

    tt_um_unload #(.MAX_IN_LEN(S_IN), .MAX_OUT_LEN(S_OUT)) dut_small (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_start(ui_start), .ui_ready(ui_ready),
        .ui_param(ui_param), .ui_weights(ui_weights[S_WW-1:0]),
        .uo_data(s_data), .uo_valid(s_valid), .uo_busy(s_busy), .uo_done(s_done)
    );

    function automatic logic [WW-1:0] rand_w();
        logic [WW-1:0] v;
        v = '0;
        for (int i = 0; i < WW / 32; i++) v = {v[WW-33:0], 32'($urandom)};
        return v;
    endfunction

    function automatic logic [7:0] ref_byte(input logic [WW-1:0] w, input int out_len,
                                            input int r, input int p, input int b);
        logic [7:0] v;
        v = '0;
        for (int k = 0; k < 8; k++) v[k] = w[IW_TB'((b * 8 + k) * 2 * out_len + r * 2 + p)];
        return v;
    endfunction

    // Expected stream: rows 0..last, MSB plane then LSB, bytes ascending.
    function automatic void fill_q(input logic [WW-1:0] w, input int bpp, input int out_len, input int param);
        int lr;
        lr = (param >= out_len) ? out_len - 1 : param;
        exp_q.delete();
        for (int r = 0; r <= lr; r++)
            for (int p = 0; p < 2; p++)
                for (int b = 0; b < bpp; b++)
                    exp_q.push_back(ref_byte(w, out_len, r, p, b));
    endfunction

    task automatic drain();
        int c;
        c = 0;
        ui_start = 1'b0;
        ui_ready = 1'b1;
        ena      = 1'b1;
        while ((uo_busy || s_busy) && c < 100) begin
            @(negedge clk);
            c++;
        end
        n_checks++;
        if (uo_busy !== 1'b0 || s_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_timeout: busy=%b small_busy=%b, required 0/0", uo_busy, s_busy);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b1; ena = 1'b1; ui_start = 1'b0; ui_ready = 1'b1; ui_param = '0; ui_weights = '0;
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({uo_data, uo_valid, uo_busy, uo_done} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: data=%h valid=%b busy=%b done=%b, required all zero",
                     uo_data, uo_valid, uo_busy, uo_done);
        end
        n_checks++;
        if ({s_data, s_valid, s_busy, s_done} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_small_outputs: data=%h valid=%b busy=%b done=%b, required all zero",
                     s_data, s_valid, s_busy, s_done);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (uo_valid !== 1'b0 || uo_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: valid=%b busy=%b, required 0/0", uo_valid, uo_busy);
        end
    endtask

    task automatic test_basic();
        logic [WW-1:0] w;
        for (int n = 0; n < WW; n++) w[IW_TB'(n)] = n[0] ^ n[4];
        ui_weights = w; ui_param = 7'd0; ui_ready = 1'b1;
        fill_q(w, BYTES_PER_PLANE, OUT_L, 0);
        @(negedge clk); ui_start = 1'b1;
        @(negedge clk); ui_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (uo_valid !== 1'b1 || uo_busy !== 1'b1 || uo_data !== exp_q[i]) begin
                n_fail++;
                $display("FAIL basic_beat%0d: valid=%b busy=%b data=%h, required 1/1/%h",
                         i, uo_valid, uo_busy, uo_data, exp_q[i]);
            end
            @(negedge clk);
        end
        n_checks++;
        if (uo_done !== 1'b1 || uo_valid !== 1'b0 || uo_data !== 8'h00 || uo_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_done: done=%b valid=%b data=%h busy=%b, required 1/0/00/1",
                     uo_done, uo_valid, uo_data, uo_busy);
        end
        @(negedge clk);
        n_checks++;
        if (uo_done !== 1'b0 || uo_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done_pulse: done=%b busy=%b, required 0/0", uo_done, uo_busy);
        end
        drain();
    endtask

    task automatic test_full();
        logic [WW-1:0] w;
        int beats, done_at;
        w = rand_w();
        ui_weights = w; ui_param = 7'd7; ui_ready = 1'b1;
        fill_q(w, BYTES_PER_PLANE, OUT_L, 7);
        beats = 0; done_at = 0;
        @(negedge clk); ui_start = 1'b1;
        @(negedge clk); ui_start = 1'b0;
        for (int c = 1; c <= 40 && done_at == 0; c++) begin
            if (uo_valid) begin
                n_checks++;
                if (beats >= exp_q.size() || uo_data !== exp_q[beats]) begin
                    n_fail++;
                    $display("FAIL full_beat%0d: data=%h, required %h", beats, uo_data, exp_q[beats]);
                end
                beats++;
            end
            if (uo_done) done_at = c;
            if (done_at == 0) @(negedge clk);
        end
        n_checks++;
        if (beats != 32) begin
            n_fail++;
            $display("FAIL full_beat_count: beats=%0d, required 32", beats);
        end
        n_checks++;
        if (done_at != 33) begin
            n_fail++;
            $display("FAIL full_done_time: done in cycle %0d after start, required 33", done_at);
        end
        @(negedge clk);
        n_checks++;
        if (uo_done !== 1'b0) begin
            n_fail++;
            $display("FAIL full_done_pulse: done=%b, required 0", uo_done);
        end
        drain();
    endtask

    task automatic test_ready_toggle();
        logic [WW-1:0] w;
        int param, cyc;
        logic r;
        int pat[4] = '{1, 0, 0, 1};
        w = rand_w();
        param = $urandom_range(1, 7);
        ui_weights = w; ui_param = 7'(param); ui_ready = 1'b1;
        fill_q(w, BYTES_PER_PLANE, OUT_L, param);
        @(negedge clk); ui_start = 1'b1;
        @(negedge clk); ui_start = 1'b0;
        ui_param = 7'($urandom);
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 400) begin
            n_checks++;
            if (uo_valid !== 1'b1 || uo_data !== exp_q[0]) begin
                n_fail++;
                $display("FAIL ready_beat c%0d: valid=%b data=%h, required 1/%h (%0d left)",
                         cyc, uo_valid, uo_data, exp_q[0], exp_q.size());
            end
            r = (cyc < 4) ? pat[cyc][0] : 1'($urandom_range(0, 1));
            ui_ready = r;
            if (r) void'(exp_q.pop_front());
            cyc++;
            @(negedge clk);
        end
        n_checks++;
        if (exp_q.size() != 0 || uo_done !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_end: left=%0d done=%b, required 0/1", exp_q.size(), uo_done);
        end
        drain();
    endtask

    task automatic test_ena_freeze();
        logic [WW-1:0] w;
        logic [7:0] sv_d;
        logic sv_v, sv_b, sv_dn;
        int i, cyc;
        w = rand_w();
        ui_weights = w; ui_param = 7'd3; ui_ready = 1'b1;
        fill_q(w, BYTES_PER_PLANE, OUT_L, 3);
        @(negedge clk); ui_start = 1'b1;
        @(negedge clk); ui_start = 1'b0;
        i = 0; cyc = 0;
        while (exp_q.size() > 0 && cyc < 200) begin
            n_checks++;
            if (uo_valid !== 1'b1 || uo_data !== exp_q[0]) begin
                n_fail++;
                $display("FAIL ena_beat%0d: valid=%b data=%h, required 1/%h", i, uo_valid, uo_data, exp_q[0]);
            end
            if (i == 1) begin
                sv_d = uo_data; sv_v = uo_valid; sv_b = uo_busy; sv_dn = uo_done;
                ena = 1'b0;
                for (int f = 0; f < 5; f++) begin
                    @(negedge clk);
                    n_checks++;
                    if ({uo_data, uo_valid, uo_busy, uo_done} !== {sv_d, sv_v, sv_b, sv_dn}) begin
                        n_fail++;
                        $display("FAIL ena_frozen%0d: data=%h valid=%b busy=%b done=%b, required %h/%b/%b/%b",
                                 f, uo_data, uo_valid, uo_busy, uo_done, sv_d, sv_v, sv_b, sv_dn);
                    end
                end
                ena = 1'b1;
            end
            void'(exp_q.pop_front());
            i++; cyc++;
            @(negedge clk);
        end
        n_checks++;
        if (uo_done !== 1'b1) begin
            n_fail++;
            $display("FAIL ena_end: done=%b, required 1", uo_done);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        logic [WW-1:0] w;
        w = rand_w();
        ui_weights = w; ui_param = 7'd7; ui_ready = 1'b1;
        fill_q(w, BYTES_PER_PLANE, OUT_L, 7);
        @(negedge clk); ui_start = 1'b1;
        @(negedge clk); ui_start = 1'b0;
        for (int i = 0; i < 10; i++) @(negedge clk);
        n_checks++;
        if (uo_valid !== 1'b1 || uo_data !== exp_q[10]) begin
            n_fail++;
            $display("FAIL rstmid_beat10: valid=%b data=%h, required 1/%h", uo_valid, uo_data, exp_q[10]);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({uo_data, uo_valid, uo_busy, uo_done} !== 11'd0) begin
            n_fail++;
            $display("FAIL rstmid_async: data=%h valid=%b busy=%b done=%b, required all zero",
                     uo_data, uo_valid, uo_busy, uo_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (uo_valid !== 1'b0 || uo_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_no_resume%0d: valid=%b busy=%b, required 0/0", i, uo_valid, uo_busy);
            end
        end
        ui_start = 1'b1;
        @(negedge clk); ui_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (uo_valid !== 1'b1 || uo_data !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rstmid_restart%0d: valid=%b data=%h, required 1/%h", i, uo_valid, uo_data, exp_q[i]);
            end
            @(negedge clk);
        end
        drain();
    endtask

    task automatic test_start_held();
        logic [WW-1:0] w;
        w = rand_w();
        ui_weights = w; ui_param = 7'd1; ui_ready = 1'b1;
        fill_q(w, BYTES_PER_PLANE, OUT_L, 1);
        @(negedge clk); ui_start = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (uo_valid !== 1'b1 || uo_data !== exp_q[i]) begin
                n_fail++;
                $display("FAIL held_beat%0d: valid=%b data=%h, required 1/%h", i, uo_valid, uo_data, exp_q[i]);
            end
            @(negedge clk);
        end
        n_checks++;
        if (uo_done !== 1'b1 || uo_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL held_done: done=%b valid=%b, required 1/0", uo_done, uo_valid);
        end
        @(negedge clk);
        n_checks++;
        if (uo_valid !== 1'b0 || uo_busy !== 1'b0 || uo_done !== 1'b0) begin
            n_fail++;
            $display("FAIL held_idle_gap: valid=%b busy=%b done=%b, required 0/0/0", uo_valid, uo_busy, uo_done);
        end
        @(negedge clk);
        n_checks++;
        if (uo_valid !== 1'b1 || uo_data !== exp_q[0]) begin
            n_fail++;
            $display("FAIL held_retrigger: valid=%b data=%h, required 1/%h", uo_valid, uo_data, exp_q[0]);
        end
        drain();
    endtask

    task automatic test_saturate();
        logic [WW-1:0] w;
        int beats, seen_done;
        w = rand_w();
        ui_weights = w; ui_param = 7'd7; ui_ready = 1'b1;
        fill_q(w, S_IN / 8, S_OUT, 7);
        beats = 0; seen_done = 0;
        @(negedge clk); ui_start = 1'b1;
        @(negedge clk); ui_start = 1'b0;
        for (int c = 0; c < 20 && seen_done == 0; c++) begin
            if (s_valid) begin
                n_checks++;
                if (beats >= exp_q.size() || s_data !== exp_q[beats]) begin
                    n_fail++;
                    $display("FAIL sat_beat%0d: data=%h, required %h", beats, s_data, exp_q[beats]);
                end
                beats++;
            end
            if (s_done) seen_done = 1;
            else @(negedge clk);
        end
        n_checks++;
        if (beats != 8 || seen_done != 1) begin
            n_fail++;
            $display("FAIL sat_count: beats=%0d done_seen=%0d, required 8/1", beats, seen_done);
        end
        drain();
    endtask

    task automatic test_snapshot();
        logic [WW-1:0] w;
        w = rand_w();
        ui_weights = w; ui_param = 7'd0; ui_ready = 1'b1;
        @(negedge clk); ui_start = 1'b1;
        @(negedge clk); ui_start = 1'b0;
        ui_weights = ~w;
`ifdef UNLOAD_SNAPSHOT_EN
        fill_q(w, BYTES_PER_PLANE, OUT_L, 0);
`else
        fill_q(~w, BYTES_PER_PLANE, OUT_L, 0);
`endif
        #1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (uo_valid !== 1'b1 || uo_data !== exp_q[i]) begin
                n_fail++;
                $display("FAIL snap_beat%0d: valid=%b data=%h, required 1/%h", i, uo_valid, uo_data, exp_q[i]);
            end
            @(negedge clk);
        end
        n_checks++;
        if (uo_done !== 1'b1) begin
            n_fail++;
            $display("FAIL snap_done: done=%b, required 1", uo_done);
        end
        ui_weights = w;
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        for (int rep = 0; rep < 3; rep++) test_ready_toggle();
        test_ena_freeze();
        test_reset_mid();
        test_start_held();
        test_saturate();
        test_snapshot();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tt_um_unload.md
TT_UM_UNLOAD -- requirements
Module: tt_um_unload

Interface
REQ-001 Parameter MAX_IN_LEN, default 16, inputs per row (weights per plane); SHALL be a multiple of 8.
REQ-002 Parameter MAX_OUT_LEN, default 8, maximum number of rows (output neurons).
REQ-003 Port clk  input  1  clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1  reset; SHALL be asynchronous and active-low.
REQ-005 Port ena  input  1  block enable; low SHALL freeze all state and hold all outputs.
REQ-006 Port ui_start  input  1  request to begin a readback; sampled only in IDLE.
REQ-007 Port ui_ready  input  1  host accepts the current beat.
REQ-008 Port ui_param  input  7  configuration; bits [2:0] give the last row index to send.
REQ-009 Port ui_weights  input  2*MAX_IN_LEN*MAX_OUT_LEN  weight array.
- Bit of input i, row r, plane p (0=MSB, 1=LSB) is at index i*2*MAX_OUT_LEN + r*2 + p.
REQ-010 Port uo_data  output  8  current beat byte.
REQ-011 Port uo_valid  output  1  uo_data holds a valid beat.
REQ-012 Port uo_busy  output  1  high in SEND and DONE.
REQ-013 Port uo_done  output  1  single-cycle pulse after the last beat is accepted.

Function
REQ-014 FSM states SHALL be IDLE, SEND and DONE.
REQ-015 IDLE->SEND on ena&&ui_start; SEND->DONE on acceptance of the final beat; DONE->IDLE after one enabled cycle.
REQ-016 At the start edge the block SHALL latch last_row=ui_param[2:0] and clear the row, plane and byte counters.
- ui_param changes during SEND SHALL be ignored.
REQ-017 A beat SHALL be accepted on an edge where ena && uo_valid && ui_ready.
- With no acceptance, uo_data and all counters SHALL hold.
REQ-018 Beat order SHALL be row-major: row 0..last_row; within a row, plane MSB then LSB; within a plane, byte 0..MAX_IN_LEN/8-1.
REQ-019 Byte b of plane p, row r: uo_data[k] SHALL equal the weight bit of input b*8+k.
REQ-020 Total beats SHALL equal (last_row+1)*2*(MAX_IN_LEN/8); 4 beats per row at defaults.
REQ-021 uo_valid SHALL be high exactly in SEND.
- The first beat SHALL be valid in the cycle after the start edge (1-cycle latency).
REQ-022 uo_done SHALL be high exactly in DONE, for one enabled cycle.
REQ-023 ui_start while busy SHALL be ignored; start held high through DONE SHALL re-trigger only from IDLE.
REQ-024 last_row >= MAX_OUT_LEN SHALL be saturated to MAX_OUT_LEN-1.
REQ-025 Counters SHALL not wrap mid-transfer; the row counter SHALL be sized $clog2(MAX_OUT_LEN).
REQ-026 uo_data SHALL be 8'h00 whenever uo_valid is low.

Reset
REQ-027 Assertion of rst_n low SHALL immediately force IDLE, clear all counters, and drive uo_data=0, uo_valid=0, uo_busy=0, uo_done=0, including mid-transfer.
REQ-028 After deassertion the block SHALL require a fresh ui_start; no partial transfer SHALL resume.

Configuration
REQ-029 Macro UNLOAD_SNAPSHOT_EN defined: ui_weights SHALL be captured into an internal register at the start edge, and all beats SHALL come from that snapshot.
REQ-030 Macro UNLOAD_SNAPSHOT_EN undefined: beats SHALL be read combinationally from live ui_weights; no snapshot register SHALL exist.

Structure
REQ-031 Shared package tt_tern_pkg SHALL hold the MAX_IN_LEN/MAX_OUT_LEN defaults, the plane encoding (MSB=0, LSB=1), BYTES_PER_PLANE and the FSM state typedef.
REQ-032 Byte selection SHALL be a sub-module tt_um_unload_mux.
- Inputs: weight array, row, plane, byte index.
- Output: 8 bits.
- Purely combinational.

Verification
REQ-033 Weights with bit n = n[0]^n[4], ui_param=3'd0, ready=1: start -> 4 beats on consecutive cycles matching REQ-019 for row 0, then uo_done for 1 cycle.
REQ-034 ui_param=3'd7, ready=1 -> 32 beats; done asserted exactly 33 cycles after the start edge.
REQ-035 ready toggled 1,0,0,1 during SEND -> uo_data held while ready=0; no beat lost or duplicated.
REQ-036 ena low for 5 cycles mid-row -> all outputs frozen; stream resumes with the same beat.
REQ-037 rst_n pulsed low at beat 10 of 32 -> outputs zero asynchronously; a subsequent start sends from row 0 beat 0.
REQ-038 With UNLOAD_SNAPSHOT_EN, ui_weights inverted after start -> beats match the pre-start value; without the macro -> beats reflect the new value.
